hzd_scoreboard: RTL and testbench

- Parametrised hazard and forwarding scoreboard for the in-order pipeline. It sits beside the decode stage.
- Tracks in-flight register writes across DEPTH downstream stages (EX … WB).
- Per read port, produces a forwarding select and a load-use stall.
- Supports configurable read-port count, register count and load latency.
- Holds the stall for as many cycles as needed; one-shot stall is no longer used.
- Keeps a stall-cycle performance counter.

---
 rtl/hzd_scoreboard_pkg.sv | 21 ++
 rtl/hzd_slot.sv | 54 +++++
 rtl/hzd_scoreboard.sv | 134 +++++++++++++
 tb/tb_hzd_scoreboard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hzd_scoreboard_pkg.sv
// Shared definitions for the hazard/forwarding scoreboard.
//   - Forwarding select encodings. The datapath operand muxes decode the
//     same values, so this encoding must not change.
//   - Bit layout of one tracked slot: {wr_reg, is_load, vld}.
//   - slot_width(): packed slot width for a given register index width.
package hzd_scoreboard_pkg;

  localparam int NO_FWD       = 0;
  localparam int FWD_FROM_EX  = 1;
  localparam int FWD_FROM_MEM = 2;
  localparam int FWD_FROM_WB  = 3;

  localparam int SLOT_VLD_BIT  = 0;
  localparam int SLOT_LOAD_BIT = 1;
  localparam int SLOT_REG_LSB  = 2;

  function automatic int slot_width(input int reg_w);
    return reg_w + SLOT_REG_LSB;
  endfunction

endpackage

// File: rtl/hzd_slot.sv
// One tracked in-flight register write (one downstream pipeline stage).
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset; clears the valid bit only
//   en      in   load slot_i (pipeline advance); 0 holds the entry
//   slot_i  in   packed {wr_reg, is_load, vld} from the previous stage
//   slot_o  out  packed {wr_reg, is_load, vld} currently held
module hzd_slot
  import hzd_scoreboard_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [slot_width(REG_W)-1:0]  slot_i,
  output logic [slot_width(REG_W)-1:0]  slot_o
);

  logic             vld_d, vld_q;
  logic             is_load_d, is_load_q;
  logic [REG_W-1:0] wr_reg_d, wr_reg_q;

  always_comb begin
    vld_d     = vld_q;
    is_load_d = is_load_q;
    wr_reg_d  = wr_reg_q;
    if (en) begin
      vld_d     = slot_i[SLOT_VLD_BIT];
      is_load_d = slot_i[SLOT_LOAD_BIT];
      wr_reg_d  = slot_i[SLOT_REG_LSB +: REG_W];
    end
  end

  // Only the valid bit needs clearing; register/load fields are don't-care
  // while the slot is invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    is_load_q <= is_load_d;
    wr_reg_q  <= wr_reg_d;
  end

  always_comb begin
    slot_o                             = '0;
    slot_o[SLOT_VLD_BIT]               = vld_q;
    slot_o[SLOT_LOAD_BIT]              = is_load_q;
    slot_o[SLOT_REG_LSB +: REG_W]      = wr_reg_q;
  end

endmodule

// File: rtl/hzd_scoreboard.sv
// Hazard and forwarding scoreboard beside the decode stage of the in-order
// pipeline. Tracks in-flight register writes over DEPTH downstream stages
// (slot 0 = EX ... slot DEPTH-1 = WB), produces a per-read-port forwarding
// select and a load-use stall, and counts stall cycles.
//
// Optional build macro: HZD_SCBD_R0_ZERO_EN
//   defined   - r0 is hardwired zero: reads of r0 never match and writes of
//               r0 never enter slot 0.
//   undefined - r0 is tracked like any other register.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   advance             pipeline enable; 0 freezes slots and counter
//   flush               redirect; kills the decode instruction
//   id_valid            decode holds a real instruction
//   id_rd_en/id_rd_reg  per-port read enable / index (port p at [p*REG_W +: REG_W])
//   id_wr_en/id_wr_reg  decode instruction destination write
//   id_is_load          decode instruction is a load
//   fwd_sel             per-port select (port p at [p*FWD_W +: FWD_W]), 0 = regfile
//   stall               hold IF/ID, bubble into EX
//   issue               decode instruction enters slot 0 this cycle
//   stall_cnt           saturating stall-cycle counter
module hzd_scoreboard
  import hzd_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int FWD_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      advance,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_RD-1:0]         id_rd_en,
  input  logic [NUM_RD*REG_W-1:0]   id_rd_reg,
  input  logic                      id_wr_en,
  input  logic [REG_W-1:0]          id_wr_reg,
  input  logic                      id_is_load,
  output logic [NUM_RD*FWD_W-1:0]   fwd_sel,
  output logic                      stall,
  output logic                      issue,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int SLOT_W = slot_width(REG_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SLOT_W-1:0] slot_in  [DEPTH];
  logic [SLOT_W-1:0] slot_out [DEPTH];
  logic [NUM_RD-1:0] rd_live;
  logic              slot0_vld;
  logic              hazard;
  logic [FWD_W-1:0]  sel_tmp;
  logic              haz_tmp;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  // ---- decode -> slot 0 (EX) boundary ----
`ifdef HZD_SCBD_R0_ZERO_EN
  assign slot0_vld = issue & id_wr_en & (id_wr_reg != '0);
  always_comb begin
    rd_live = '0;
    for (int p = 0; p < NUM_RD; p++)
      rd_live[p] = id_rd_en[p] & (id_rd_reg[p*REG_W +: REG_W] != '0);
  end
`else
  assign slot0_vld = issue & id_wr_en;
  assign rd_live   = id_rd_en;
`endif

  always_comb begin
    for (int k = 0; k < DEPTH; k++) slot_in[k] = '0;
    slot_in[0][SLOT_VLD_BIT]          = slot0_vld;
    slot_in[0][SLOT_LOAD_BIT]         = id_is_load;
    slot_in[0][SLOT_REG_LSB +: REG_W] = id_wr_reg;
    for (int k = 1; k < DEPTH; k++) slot_in[k] = slot_out[k-1];
  end

  // ---- slot k-1 -> slot k boundaries (EX ... WB) ----
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    hzd_slot #(.REG_W(REG_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (advance),
      .slot_i (slot_in[k]),
      .slot_o (slot_out[k])
    );
  end

  // Scan oldest to youngest so the youngest matching slot overwrites.
  always_comb begin
    fwd_sel = '0;
    hazard  = 1'b0;
    sel_tmp = '0;
    haz_tmp = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      sel_tmp = FWD_W'(NO_FWD);
      haz_tmp = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (rd_live[p] && slot_out[k][SLOT_VLD_BIT] &&
            (slot_out[k][SLOT_REG_LSB +: REG_W] == id_rd_reg[p*REG_W +: REG_W])) begin
          sel_tmp = FWD_W'(FWD_FROM_EX + k);
          // Load data is not forwardable until it reaches slot LOAD_LAT.
          haz_tmp = slot_out[k][SLOT_LOAD_BIT] && (k < LOAD_LAT);
        end
      end
      fwd_sel[p*FWD_W +: FWD_W] = sel_tmp;
      hazard                    = hazard | haz_tmp;
    end
  end

  assign stall = id_valid & hazard & ~flush;
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && advance) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hzd_scoreboard.sv
module tb_hzd_scoreboard;
  import hzd_scoreboard_pkg::*;

`ifdef HZD_SCBD_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, advance, flush, id_valid, id_wr_en, id_is_load;
  logic [1:0] id_rd_en;
  logic [7:0] id_rd_reg;
  logic [3:0] id_wr_reg;

  logic [3:0]  fwd_a;
  logic        stall_a, issue_a;
  logic [15:0] cnt_a;
  logic [5:0]  fwd_b;
  logic        stall_b, issue_b;
  logic [3:0]  cnt_b;

  // Instance A: default configuration.
  hzd_scoreboard u_dut_a (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rd_reg(id_rd_reg),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .fwd_sel(fwd_a), .stall(stall_a), .issue(issue_a), .stall_cnt(cnt_a)
  );

  // Instance B: longer load latency, narrow counter to reach saturation.
  hzd_scoreboard #(.NUM_REGS(16), .NUM_RD(2), .DEPTH(4), .LOAD_LAT(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rd_reg(id_rd_reg),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .fwd_sel(fwd_b), .stall(stall_b), .issue(issue_b), .stall_cnt(cnt_b)
  );

  typedef struct {
    string tag;
    int    inst;
    int    f0;
    int    f1;
    logic  st;
    logic  iss;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    if (e.inst == 0) begin
      chk({e.tag, ".fwd0"},  32'(fwd_a[1:0]), e.f0);
      chk({e.tag, ".fwd1"},  32'(fwd_a[3:2]), e.f1);
      chk({e.tag, ".stall"}, 32'(stall_a),    32'(e.st));
      chk({e.tag, ".issue"}, 32'(issue_a),    32'(e.iss));
      chk({e.tag, ".cnt"},   32'(cnt_a),      e.cnt);
    end else begin
      chk({e.tag, ".fwd0"},  32'(fwd_b[2:0]), e.f0);
      chk({e.tag, ".fwd1"},  32'(fwd_b[5:3]), e.f1);
      chk({e.tag, ".stall"}, 32'(stall_b),    32'(e.st));
      chk({e.tag, ".issue"}, 32'(issue_b),    32'(e.iss));
      chk({e.tag, ".cnt"},   32'(cnt_b),      e.cnt);
    end
  endtask

  // Drive one decode cycle, queue its expectation, check at the falling edge.
  task automatic step(input string tag, input int inst,
                      input logic v, input logic [1:0] re, input logic [3:0] r0,
                      input logic [3:0] r1, input logic we, input logic [3:0] wr,
                      input logic ld, input logic fl, input logic adv,
                      input int ef0, input int ef1, input logic est,
                      input logic eiss, input int ecnt);
    id_valid   = v;
    id_rd_en   = re;
    id_rd_reg  = {r1, r0};
    id_wr_en   = we;
    id_wr_reg  = wr;
    id_is_load = ld;
    flush      = fl;
    advance    = adv;
    exp_q.push_back('{tag, inst, ef0, ef1, est, eiss, ecnt});
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int inst, input int ecnt);
    step(tag, inst, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ecnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_valid = 0; id_rd_en = 0; id_rd_reg = 0; id_wr_en = 0;
    id_wr_reg = 0; id_is_load = 0; flush = 0; advance = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int c;

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rd_en = 0; id_rd_reg = 0; id_wr_en = 0;
    id_wr_reg = 0; id_is_load = 0; flush = 0; advance = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state and empty scoreboard
    idle("rst", 0, 0);
    step("rd_empty", 0, 1, 2'b01, 3, 0, 0, 0, 0, 0, 1, NO_FWD, 0, 0, 1, 0);

    // Match priority / ageing through EX, MEM, WB
    step("wr_r3",    0, 1, 2'b00, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 1, 0);
    step("fwd_ex",   0, 1, 2'b01, 3, 0, 0, 0, 0, 0, 1, FWD_FROM_EX, 0, 0, 1, 0);
    step("fwd_mem",  0, 0, 2'b01, 3, 0, 0, 0, 0, 0, 1, FWD_FROM_MEM, 0, 0, 0, 0);
    step("fwd_wb",   0, 1, 2'b11, 3, 3, 0, 0, 0, 0, 1, FWD_FROM_WB, FWD_FROM_WB, 0, 1, 0);

    // Youngest writer wins
    step("wr_r4a",   0, 1, 2'b00, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0, 1, 0);
    step("wr_r4b",   0, 1, 2'b10, 0, 4, 1, 4, 0, 0, 1, 0, 1, 0, 1, 0);
    step("young",    0, 1, 2'b01, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);

    // A write with id_wr_en=0 never matches
    step("noen_w",   0, 1, 2'b00, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 1, 0);
    step("noen_r",   0, 1, 2'b01, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

    // Load-use, default latency: one stall cycle
    step("lw_r5",    0, 1, 2'b00, 0, 0, 1, 5, 1, 0, 1, 0, 0, 0, 1, 0);
    step("lu_stall", 0, 1, 2'b10, 0, 5, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    step("lu_go",    0, 1, 2'b10, 0, 5, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1);

    // Flush while stall would be asserted
    step("lw_r6",    0, 1, 2'b00, 0, 0, 1, 6, 1, 0, 1, 0, 0, 0, 1, 1);
    step("fl_stall", 0, 1, 2'b01, 6, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    step("fl_after", 0, 1, 2'b01, 6, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 1);
    step("fl_wb",    0, 0, 2'b01, 6, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1);
    step("fl_ret",   0, 0, 2'b01, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    // Freeze with a pending load hazard
    step("lw_r8",    0, 1, 2'b00, 0, 0, 1, 8, 1, 0, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      step("frz",    0, 1, 2'b01, 8, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    step("frz_rel",  0, 1, 2'b01, 8, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1);
    step("frz_go",   0, 1, 2'b01, 8, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 2);

    // Reset in the middle of a stall
    step("lw_r9",    0, 1, 2'b00, 0, 0, 1, 9, 1, 0, 1, 0, 0, 0, 1, 2);
    rst_n = 1'b0;
    step("rst_mid",  0, 1, 2'b01, 9, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 2);
    rst_n = 1'b1;
    step("rst_aft",  0, 1, 2'b01, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

    // r0 handling (depends on build option)
    step("wr_r0",    0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    step("rd_r0",    0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, R0Z ? 0 : 1, 0, 0, 1, 0);
    step("lw_r0",    0, 1, 2'b00, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    step("lu_r0",    0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, R0Z ? 0 : 1, 0, !R0Z, R0Z, 0);

    // Longer load latency (DEPTH=4, LOAD_LAT=2)
    do_reset();
    step("b_lw",     1, 1, 2'b00, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 1, 0);
    step("b_st1",    1, 1, 2'b01, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    step("b_st2",    1, 1, 2'b01, 2, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1);
    step("b_go",     1, 1, 2'b01, 2, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 2);

    // Counter saturation: back-to-back "LW r2 <- [r2]" stalls twice per issue
    do_reset();
    c = 0;
    step("b_sat0",   1, 1, 2'b01, 2, 0, 1, 2, 1, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step("b_sat_s1", 1, 1, 2'b01, 2, 0, 1, 2, 1, 0, 1, 1, 0, 1, 0, c);
      c = (c == 15) ? 15 : c + 1;
      step("b_sat_s2", 1, 1, 2'b01, 2, 0, 1, 2, 1, 0, 1, 2, 0, 1, 0, c);
      c = (c == 15) ? 15 : c + 1;
      step("b_sat_go", 1, 1, 2'b01, 2, 0, 1, 2, 1, 0, 1, 3, 0, 0, 1, c);
    end
    idle("b_sat_end", 1, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
